// File: rtl/ssd_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_scheduler
// Purpose  : Double-buffered, guard-slotted scan of NUM_DIGITS hex digits onto
//            the shared seven-segment anode/cathode bus.
// Options  : LZ_BLANK_EN - blank leading zero digits (mask rebuilt at each swap)
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_scheduler #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 131072,
    parameter int GUARD_CYCLES = 1024
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp,
    input  logic        load_req,
    output logic        load_ack,
    output logic        frame_done,
    output logic [7:0]  An,
    output logic [7:0]  Cath
);

    localparam int c_MAX_CYC = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_DIGIT_LAST = c_CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD_CYCLES - 1);
    localparam logic [2:0]         c_LAST_IDX   = 3'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]           r_idx, w_idx_nxt;
    logic                 r_started;
    logic                 r_pending;
    logic [31:0]          r_sh_digits, r_act_digits;
    logic [7:0]           r_sh_en, r_sh_dp, r_act_en, r_act_dp;
    logic                 w_frame_end, w_swap, w_capture;
    logic [7:0]           w_an_nxt, w_cath_nxt;
    logic [7:0]           w_lit;

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'b0000001;
            4'h1: hex7seg = 7'b1001111;
            4'h2: hex7seg = 7'b0010010;
            4'h3: hex7seg = 7'b0000110;
            4'h4: hex7seg = 7'b1001100;
            4'h5: hex7seg = 7'b0100100;
            4'h6: hex7seg = 7'b0100000;
            4'h7: hex7seg = 7'b0001111;
            4'h8: hex7seg = 7'b0000000;
            4'h9: hex7seg = 7'b0000100;
            4'hA: hex7seg = 7'b0001000;
            4'hB: hex7seg = 7'b1100000;
            4'hC: hex7seg = 7'b0110001;
            4'hD: hex7seg = 7'b1000010;
            4'hE: hex7seg = 7'b0110000;
            default: hex7seg = 7'b0111000;
        endcase
    endfunction

`ifdef LZ_BLANK_EN
    logic [7:0] r_mask, w_mask_nxt;
    logic       w_run;

    // Walk down from the top; disabled digits neither blank nor stop the run.
    always_comb begin
        w_mask_nxt = '0;
        w_run      = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (i < NUM_DIGITS && r_sh_en[i]) begin
                if (w_run && r_sh_digits[4*i +: 4] == 4'h0 && !r_sh_dp[i])
                    w_mask_nxt[i] = 1'b1;
                else
                    w_run = 1'b0;
            end
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset)
            r_mask <= '0;
        else if (w_swap)
            r_mask <= w_mask_nxt;
    end

    assign w_lit = r_act_en & ~r_mask;
`else
    assign w_lit = r_act_en;
`endif

    assign w_capture = load_req & ~r_pending;
    assign w_swap    = w_frame_end & r_pending;

    // Outputs are derived from the next state so An/Cath flip with the state.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_frame_end = 1'b0;
        w_an_nxt    = 8'hFF;
        w_cath_nxt  = 8'hFF;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == c_GUARD_LAST) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = '0;
                    if (r_started)
                        w_idx_nxt = (r_idx == c_LAST_IDX) ? 3'd0 : r_idx + 3'd1;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == c_DIGIT_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_frame_end = (r_idx == c_LAST_IDX);
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_state_nxt == ST_DRIVE) begin
            w_an_nxt[w_idx_nxt] = ~w_lit[w_idx_nxt];
            w_cath_nxt = {hex7seg(r_act_digits[{w_idx_nxt, 2'b00} +: 4]), ~r_act_dp[w_idx_nxt]};
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_BLANK;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_started  <= 1'b0;
            An         <= 8'hFF;
            Cath       <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            if (r_state == ST_BLANK && w_state_nxt == ST_DRIVE)
                r_started <= 1'b1;
            An         <= w_an_nxt;
            Cath       <= w_cath_nxt;
            frame_done <= w_frame_end;
        end
    end

    // Capture and swap are exclusive: capture needs pending=0, swap needs pending=1.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_pending    <= 1'b0;
            load_ack     <= 1'b0;
            r_sh_digits  <= '0;
            r_sh_en      <= '0;
            r_sh_dp      <= '0;
            r_act_digits <= '0;
            r_act_en     <= '0;
            r_act_dp     <= '0;
        end else begin
            load_ack <= w_capture;
            if (w_capture) begin
                r_sh_digits <= digits;
                r_sh_en     <= digit_en;
                r_sh_dp     <= dp;
                r_pending   <= 1'b1;
            end else if (w_swap) begin
                r_act_digits <= r_sh_digits;
                r_act_en     <= r_sh_en;
                r_act_dp     <= r_sh_dp;
                r_pending    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
